// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants and the occupancy-step helper.
// The pointer stages reuse the same constants.
package fifo_pkg;
  localparam int ADDR_W       = 4;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int CNT_W        = ADDR_W + 1;
  localparam int AF_LEVEL_DEF = 12;
  localparam int AE_LEVEL_DEF = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  // Accepted requests move the count by one. Simultaneous accepts cancel out.
  function automatic cnt_t cnt_step(input cnt_t cnt, input logic wa, input logic ra);
    cnt_t res;
    case ({wa, ra})
      2'b10:   res = cnt + CNT_W'(1);
      2'b01:   res = cnt - CNT_W'(1);
      default: res = cnt;
    endcase
    return res;
  endfunction
endpackage

// File: rtl/fifo_status_if.sv
// Request/status bundle between the FIFO control stages and fifo_status.
// The fifo_peak signal exists only when FIFO_STATUS_PEAK_EN is defined.
interface fifo_status_if;
  import fifo_pkg::*;

  logic wr_req;
  logic rd_req;
  logic err_clr;
  cnt_t fifo_count;
  logic fifo_empty;
  logic fifo_full;
  logic fifo_almost_empty;
  logic fifo_almost_full;
  logic fifo_overflow;
  logic fifo_underflow;
`ifdef FIFO_STATUS_PEAK_EN
  cnt_t fifo_peak;
`endif

  modport master (
    output wr_req, rd_req, err_clr,
    input  fifo_count, fifo_empty, fifo_full, fifo_almost_empty,
    input  fifo_almost_full, fifo_overflow, fifo_underflow
`ifdef FIFO_STATUS_PEAK_EN
    , input fifo_peak
`endif
  );

  modport slave (
    input  wr_req, rd_req, err_clr,
    output fifo_count, fifo_empty, fifo_full, fifo_almost_empty,
    output fifo_almost_full, fifo_overflow, fifo_underflow
`ifdef FIFO_STATUS_PEAK_EN
    , output fifo_peak
`endif
  );
endinterface

// File: rtl/fifo_sticky_flag.sv
// Sticky error bit: set has priority over clear.
module fifo_sticky_flag (
  input  logic clk,
  input  logic rst_edge_n,
  input  logic set,
  input  logic clr,
  output logic flag
);
  logic flag_r;

  // Hold the flag until cleared; a same-cycle set keeps it high.
  always_ff @(posedge clk) begin
    if (!rst_edge_n) begin
      flag_r <= 1'b0;
    end else if (set) begin
      flag_r <= 1'b1;
    end else if (clr) begin
      flag_r <= 1'b0;
    end else begin
      flag_r <= flag_r;
    end
  end

  assign flag = flag_r;
endmodule

// File: rtl/fifo_status.sv
// FIFO occupancy counter with registered level flags and sticky overflow/underflow.
// Optional peak-occupancy tracking is enabled with FIFO_STATUS_PEAK_EN.
module fifo_status
  import fifo_pkg::*;
#(
  parameter int AF_LEVEL = AF_LEVEL_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic         clk,
  input  logic         rst_edge_n,
  fifo_status_if.slave bus
);
  cnt_t cnt_r;
  cnt_t cnt_nxt_s;
  logic empty_r;
  logic full_r;
  logic aempty_r;
  logic afull_r;
  logic wa_s;
  logic ra_s;
  logic ovf_s;
  logic unf_s;

  // Gate requests with the registered flags so the count saturates at 0 and DEPTH.
  always_comb begin
    wa_s      = bus.wr_req & ~full_r;
    ra_s      = bus.rd_req & ~empty_r;
    cnt_nxt_s = cnt_step(cnt_r, wa_s, ra_s);
  end

  // Count and level flags update together from the next count.
  always_ff @(posedge clk) begin
    if (!rst_edge_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      aempty_r <= 1'b1;
      afull_r  <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      empty_r  <= (cnt_nxt_s == CNT_W'(0));
      full_r   <= (cnt_nxt_s == CNT_W'(DEPTH));
      aempty_r <= (cnt_nxt_s <= CNT_W'(AE_LEVEL));
      afull_r  <= (cnt_nxt_s >= CNT_W'(AF_LEVEL));
    end
  end

  fifo_sticky_flag u_ovf (
    .clk        (clk),
    .rst_edge_n (rst_edge_n),
    .set        (bus.wr_req & full_r),
    .clr        (bus.err_clr),
    .flag       (ovf_s)
  );

  fifo_sticky_flag u_unf (
    .clk        (clk),
    .rst_edge_n (rst_edge_n),
    .set        (bus.rd_req & empty_r),
    .clr        (bus.err_clr),
    .flag       (unf_s)
  );

`ifdef FIFO_STATUS_PEAK_EN
  cnt_t peak_r;
  cnt_t peak_nxt_s;

  // Clearing restarts the peak from the occupancy being entered this cycle.
  always_comb begin
    peak_nxt_s = peak_r;
    if (bus.err_clr) begin
      peak_nxt_s = cnt_nxt_s;
    end else if (cnt_nxt_s > peak_r) begin
      peak_nxt_s = cnt_nxt_s;
    end else begin
      peak_nxt_s = peak_r;
    end
  end

  // Peak register.
  always_ff @(posedge clk) begin
    if (!rst_edge_n) begin
      peak_r <= {CNT_W{1'b0}};
    end else begin
      peak_r <= peak_nxt_s;
    end
  end

  assign bus.fifo_peak = peak_r;
`endif

  assign bus.fifo_count        = cnt_r;
  assign bus.fifo_empty        = empty_r;
  assign bus.fifo_full         = full_r;
  assign bus.fifo_almost_empty = aempty_r;
  assign bus.fifo_almost_full  = afull_r;
  assign bus.fifo_overflow     = ovf_s;
  assign bus.fifo_underflow    = unf_s;
endmodule

// File: tb/tb_fifo_status.sv
// Directed self-checking bench for fifo_status; peak checks run when FIFO_STATUS_PEAK_EN is defined.
module tb_fifo_status;
  import fifo_pkg::*;

  logic clk;
  logic rst_edge_n;
  int   n_checks;
  int   n_pass;

  fifo_status_if bus ();

  fifo_status dut (
    .clk        (clk),
    .rst_edge_n (rst_edge_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Expected flags follow from the expected count using the default levels.
  task automatic check_state(input string tag, input int cnt, input int ovf, input int unf);
    check({tag, ".count"}, int'(bus.fifo_count), cnt);
    check({tag, ".empty"}, int'(bus.fifo_empty), int'(cnt == 0));
    check({tag, ".full"},  int'(bus.fifo_full),  int'(cnt == 16));
    check({tag, ".aempty"}, int'(bus.fifo_almost_empty), int'(cnt <= 2));
    check({tag, ".afull"}, int'(bus.fifo_almost_full), int'(cnt >= 12));
    check({tag, ".ovf"},   int'(bus.fifo_overflow), ovf);
    check({tag, ".unf"},   int'(bus.fifo_underflow), unf);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic clr);
    bus.wr_req  = wr;
    bus.rd_req  = rd;
    bus.err_clr = clr;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst_edge_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // 1: reset state
    step(1);
    check_state("reset", 0, 0, 0);
    rst_edge_n = 1'b1;

    // 2: fill to full, then one write too many
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      check_state($sformatf("fill%0d", i), i, 0, 0);
    end
    step(1);
    check_state("wr_full", 16, 1, 0);
    drive(1'b0, 1'b0, 1'b0);
    step(1);
    check_state("ovf_hold", 16, 1, 0);

    // 3: drain to empty, one read too many, then clear
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      step(1);
      check_state($sformatf("drain%0d", i), i, 1, 0);
    end
    step(1);
    check_state("rd_empty", 0, 1, 1);
    drive(1'b0, 1'b0, 1'b1);
    step(1);
    check_state("err_clr", 0, 0, 0);

    // 4: simultaneous requests at mid, full and empty
    drive(1'b1, 1'b0, 1'b0);
    step(5);
    check_state("to5", 5, 0, 0);
    drive(1'b1, 1'b1, 1'b0);
    step(1);
    check_state("both5", 5, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    step(11);
    check_state("to16", 16, 0, 0);
    drive(1'b1, 1'b1, 1'b0);
    step(1);
    check_state("both16", 15, 1, 0);
    drive(1'b0, 1'b0, 1'b1);
    step(1);
    check_state("clr2", 15, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    step(1);
    check_state("refull", 16, 0, 0);
    drive(1'b1, 1'b0, 1'b1);
    step(1);
    check_state("set_wins", 16, 1, 0);
    drive(1'b0, 1'b0, 1'b1);
    step(1);
    check_state("clr3", 16, 0, 0);
    drive(1'b0, 1'b1, 1'b0);
    step(16);
    check_state("to0", 0, 0, 0);
    drive(1'b1, 1'b1, 1'b0);
    step(1);
    check_state("both0", 1, 0, 1);

    // 5: reset mid-operation with a write pending
    drive(1'b1, 1'b0, 1'b0);
    step(8);
    check_state("to9", 9, 0, 1);
    rst_edge_n = 1'b0;
    step(1);
    check_state("mid_reset", 0, 0, 0);
    rst_edge_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

`ifdef FIFO_STATUS_PEAK_EN
    // 6: peak tracking and restart on clear
    check("peak_reset", int'(bus.fifo_peak), 0);
    drive(1'b1, 1'b0, 1'b0);
    step(10);
    check("peak10", int'(bus.fifo_peak), 10);
    drive(1'b0, 1'b1, 1'b0);
    step(4);
    check("cnt6", int'(bus.fifo_count), 6);
    check("peak_hold", int'(bus.fifo_peak), 10);
    drive(1'b0, 1'b0, 1'b1);
    step(1);
    check("peak_clr", int'(bus.fifo_peak), 6);
    drive(1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
